// File: rtl/lcd_char_refresh.sv
// Character-LCD (HD44780-compatible) refresh engine: power-up wait, one-time init,
// then rewrites the whole display from a shadow copy when text changes or on request.
module lcd_char_refresh #(
    parameter int COLS    = 16,
    parameter int ROWS    = 2,
    parameter int PWR_DLY = 750000,
    parameter int EN_W    = 12,
    parameter int CMD_DLY = 2500,
    parameter int CLR_DLY = 100000,
    parameter int AUTO    = 1
) (
    input  logic                   in_CLK,
    input  logic                   in_RST,
    input  logic [ROWS*COLS*8-1:0] in_TEXT,
    input  logic                   in_REFRESH,
    output logic                   out_BUSY,
    output logic                   out_FRAME_DONE,
    output logic [7:0]             LCD_DATA,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    output logic                   LCD_EN
);
    localparam int NCH  = ROWS * COLS;
    localparam int M1   = (PWR_DLY > CLR_DLY) ? PWR_DLY : CLR_DLY;
    localparam int M2   = (CMD_DLY > EN_W) ? CMD_DLY : EN_W;
    localparam int MAXD = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {T_PWR, T_INIT, T_IDLE, T_LATCH, T_ADDR, T_CHAR, T_DONE} top_e;
    typedef enum logic [1:0] {W_SETUP, W_PULSE, W_HOLD, W_WAIT} wr_e;

    top_e               top_q, top_d;
    wr_e                wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CLW-1:0]     col_q, col_d;
    logic [NCH*8-1:0]   shadow_q, shadow_d;
    logic               valid_q, valid_d;
    logic               pend_q, pend_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               in_write;
    logic               wr_done;
    logic [CW-1:0]      wait_len;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return (ROWS == 1) ? 8'h30 : 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [RW-1:0] r);
        int unsigned ri;
        ri = 32'(r);
        case (ri)
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    // Byte (r*COLS+c) counted from the MSB end of the text vector.
    function automatic logic [7:0] char_at(input logic [NCH*8-1:0] s,
                                           input logic [RW-1:0] r,
                                           input logic [CLW-1:0] c);
        int unsigned      k;
        logic [NCH*8-1:0] t;
        k = 32'(r) * 32'(COLS) + 32'(c);
        t = s << (k * 8);
        return t[NCH*8-1 -: 8];
    endfunction

    assign in_write = (top_q == T_INIT) || (top_q == T_ADDR) || (top_q == T_CHAR);
    assign wait_len = (!rs_q && data_q == 8'h01) ? CW'(CLR_DLY) : CW'(CMD_DLY);
    assign wr_done  = ((wr_q == W_HOLD) && (wait_len == '0)) ||
                      ((wr_q == W_WAIT) && (cnt_q == wait_len - 1'b1));

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            top_q    <= T_PWR;
            wr_q     <= W_SETUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            rs_q     <= 1'b0;
        end else begin
            top_q    <= top_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
        end
    end

    // The next byte is loaded on the same edge that enters SETUP, so RS/DATA
    // are valid for the whole SETUP cycle and never move during PULSE/HOLD/WAIT.
    always_comb begin
        top_d    = top_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        pend_d   = pend_q | (in_REFRESH && (top_q != T_IDLE));
        data_d   = data_q;
        rs_d     = rs_q;

        if (in_write) begin
            case (wr_q)
                W_SETUP: begin
                    wr_d  = W_PULSE;
                    cnt_d = '0;
                end
                W_PULSE: begin
                    if (cnt_q == CW'(EN_W - 1)) begin
                        wr_d  = W_HOLD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                W_HOLD: begin
                    wr_d  = W_WAIT;
                    cnt_d = '0;
                end
                default: cnt_d = cnt_q + 1'b1;
            endcase
        end

        case (top_q)
            T_PWR: begin
                if (cnt_q == CW'(PWR_DLY - 1)) begin
                    top_d  = T_INIT;
                    idx_d  = '0;
                    wr_d   = W_SETUP;
                    cnt_d  = '0;
                    data_d = init_cmd(2'd0);
                    rs_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            T_INIT: begin
                if (wr_done) begin
                    if (idx_q == 2'd3) begin
                        top_d = T_IDLE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        wr_d   = W_SETUP;
                        cnt_d  = '0;
                        data_d = init_cmd(idx_q + 2'd1);
                        rs_d   = 1'b0;
                    end
                end
            end
            T_IDLE: begin
                if (pend_q || in_REFRESH || !valid_q ||
                    ((AUTO != 0) && (in_TEXT != shadow_q))) begin
                    top_d = T_LATCH;
                end
            end
            T_LATCH: begin
                shadow_d = in_TEXT;
                valid_d  = 1'b1;
                pend_d   = 1'b0;
                row_d    = '0;
                top_d    = T_ADDR;
                wr_d     = W_SETUP;
                cnt_d    = '0;
                data_d   = addr_cmd('0);
                rs_d     = 1'b0;
            end
            T_ADDR: begin
                if (wr_done) begin
                    top_d  = T_CHAR;
                    col_d  = '0;
                    wr_d   = W_SETUP;
                    cnt_d  = '0;
                    data_d = char_at(shadow_q, row_q, '0);
                    rs_d   = 1'b1;
                end
            end
            T_CHAR: begin
                if (wr_done) begin
                    if (col_q == CLW'(COLS - 1)) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            top_d = T_DONE;
                        end else begin
                            row_d  = row_q + 1'b1;
                            top_d  = T_ADDR;
                            wr_d   = W_SETUP;
                            cnt_d  = '0;
                            data_d = addr_cmd(row_q + 1'b1);
                            rs_d   = 1'b0;
                        end
                    end else begin
                        col_d  = col_q + 1'b1;
                        wr_d   = W_SETUP;
                        cnt_d  = '0;
                        data_d = char_at(shadow_q, row_q, col_q + 1'b1);
                        rs_d   = 1'b1;
                    end
                end
            end
            T_DONE:  top_d = T_IDLE;
            default: top_d = T_PWR;
        endcase
    end

    always_comb begin
        LCD_EN         = in_write && (wr_q == W_PULSE);
        LCD_RS         = rs_q;
        LCD_DATA       = data_q;
        LCD_RW         = 1'b0;
        out_BUSY       = (top_q != T_IDLE);
        out_FRAME_DONE = (top_q == T_DONE);
    end

endmodule

// File: tb/tb_lcd_char_refresh.sv
// Bench for lcd_char_refresh: scoreboard of expected LCD writes checked on each EN falling edge.
module tb_lcd_char_refresh;
    logic        clk = 1'b0;
    logic        rst;
    logic        refresh;
    logic        zero_ref = 1'b0;
    logic [63:0] m_text;
    logic [63:0] f_text = "ABCDEFGH";
    logic [31:0] o_text = "ABCD";

    logic       m_busy, m_fd, m_rs, m_rw, m_en;
    logic [7:0] m_data;
    logic       f_busy, f_fd, f_rs, f_rw, f_en;
    logic [7:0] f_data;
    logic       o_busy, o_fd, o_rs, o_rw, o_en;
    logic [7:0] o_data;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;
    } wr_t;

    wr_t        q[$];
    logic [7:0] obs4[$];
    logic [7:0] obs1[$];

    int n_cmp = 0;
    int n_err = 0;
    int hicnt = 0, lowcnt = 0, gap_obs = 0, wcnt = 0, fd_cnt = 0;
    logic       prev_en = 1'b0, f_prev = 1'b0, o_prev = 1'b0;
    logic [8:0] prev_s = '0, latched = '0, cur;

    always #5 clk = ~clk;

    lcd_char_refresh #(.COLS(4), .ROWS(2), .PWR_DLY(10), .EN_W(2), .CMD_DLY(4),
                       .CLR_DLY(8), .AUTO(1)) dut (
        .in_CLK(clk), .in_RST(rst), .in_TEXT(m_text), .in_REFRESH(refresh),
        .out_BUSY(m_busy), .out_FRAME_DONE(m_fd), .LCD_DATA(m_data),
        .LCD_RS(m_rs), .LCD_RW(m_rw), .LCD_EN(m_en));

    lcd_char_refresh #(.COLS(2), .ROWS(4), .PWR_DLY(10), .EN_W(2), .CMD_DLY(4),
                       .CLR_DLY(8), .AUTO(1)) dut4 (
        .in_CLK(clk), .in_RST(rst), .in_TEXT(f_text), .in_REFRESH(zero_ref),
        .out_BUSY(f_busy), .out_FRAME_DONE(f_fd), .LCD_DATA(f_data),
        .LCD_RS(f_rs), .LCD_RW(f_rw), .LCD_EN(f_en));

    lcd_char_refresh #(.COLS(4), .ROWS(1), .PWR_DLY(10), .EN_W(2), .CMD_DLY(4),
                       .CLR_DLY(8), .AUTO(1)) dut1 (
        .in_CLK(clk), .in_RST(rst), .in_TEXT(o_text), .in_REFRESH(zero_ref),
        .out_BUSY(o_busy), .out_FRAME_DONE(o_fd), .LCD_DATA(o_data),
        .LCD_RS(o_rs), .LCD_RW(o_rw), .LCD_EN(o_en));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d, input int gap);
        wr_t w;
        w.rs = rs; w.d = d; w.gap = gap;
        q.push_back(w);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h0C, 6);
        push(1'b0, 8'h01, 6);
        push(1'b0, 8'h06, 10);
    endtask

    task automatic push_frame(input logic [63:0] t, input int first_gap);
        push(1'b0, 8'h80, first_gap);
        for (int c = 0; c < 4; c++) push(1'b1, t[(7 - c) * 8 +: 8], 6);
        push(1'b0, 8'hC0, 6);
        for (int c = 0; c < 4; c++) push(1'b1, t[(3 - c) * 8 +: 8], 6);
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && fd_cnt >= target) break;
        end
        chk("frame_wait_in_budget", (i < budget), 1);
        repeat (2) @(negedge clk);
        chk("fd_count", fd_cnt, target);
        chk("busy_idle", m_busy, 1'b0);
    endtask

    task automatic check_power_quiet();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pwr_en_low", m_en, 1'b0);
        end
    endtask

    // Main DUT monitor: write completion is the first low sample after EN high.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            hicnt   = 0;
            lowcnt  = 0;
        end else begin
            cur = {m_rs, m_data};
            if (m_fd) fd_cnt++;
            if (m_en) begin
                if (!prev_en) begin
                    gap_obs = lowcnt;
                    chk("setup_stable", cur, prev_s);
                    latched = cur;
                    hicnt = 0;
                end else begin
                    chk("pulse_stable", cur, latched);
                end
                hicnt++;
            end else if (prev_en) begin
                wr_t w;
                wcnt++;
                chk("hold_stable", cur, latched);
                chk("en_width", hicnt, 2);
                n_cmp++;
                assert (q.size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected_write: observed rs=%0b data=%0h expected none", m_rs, m_data);
                end
                if (q.size() > 0) begin
                    w = q.pop_front();
                    chk("wr_rs", m_rs, w.rs);
                    chk("wr_data", m_data, w.d);
                    if (w.gap != 0) chk("wr_gap", gap_obs, w.gap);
                end
                lowcnt = 1;
            end else begin
                lowcnt++;
            end
            prev_en = m_en;
            prev_s  = cur;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            f_prev = 1'b0;
            o_prev = 1'b0;
        end else begin
            if (f_prev && !f_en && !f_rs) obs4.push_back(f_data);
            if (o_prev && !o_en && !o_rs) obs1.push_back(o_data);
            f_prev = f_en;
            o_prev = o_en;
        end
    end

    initial begin
        logic [7:0]  exp4[8];
        logic [63:0] t1, t2;
        int          w0, i;

        exp4 = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80, 8'hC0, 8'h94, 8'hD4};
        t1 = "ABCDWXYZ";
        t2 = "ABCEWXYZ";
        rst = 1'b1;
        refresh = 1'b0;
        m_text = t1;

        repeat (3) @(negedge clk);
        chk("rst_en", m_en, 1'b0);
        chk("rst_rs", m_rs, 1'b0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_rw", m_rw, 1'b0);
        chk("rst_busy", m_busy, 1'b1);
        chk("rst_fd", m_fd, 1'b0);

        // Power-up, init and first frame
        @(posedge clk); #1 rst = 1'b0;
        push_init();
        push_frame(t1, 8);
        check_power_quiet();
        wait_frames(1, 2000);

        // Other geometries ran alongside from the same reset
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!f_busy && !o_busy) break;
        end
        chk("geom_wait_in_budget", (i < 3000), 1);
        chk("r4_ncmd", obs4.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("r4_cmd", (k < obs4.size()) ? {24'h0, obs4[k]} : 32'hFFFF_FFFF, exp4[k]);
        chk("r1_first_cmd", (obs1.size() > 0) ? {24'h0, obs1[0]} : 32'hFFFF_FFFF, 8'h30);
        chk("r1_ncmd", obs1.size(), 5);

        // Stable text: nothing written until a refresh
        w0 = wcnt;
        repeat (200) @(negedge clk);
        chk("stable_no_writes", wcnt, w0);
        push_frame(t1, 0);
        pulse_refresh();
        wait_frames(2, 2000);
        repeat (50) @(negedge clk);
        chk("refresh_one_frame", wcnt, w0 + 10);

        // Text change mid-frame: frame finishes from shadow, next one follows at once
        w0 = wcnt;
        push_frame(t1, 0);
        pulse_refresh();
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wcnt >= w0 + 3) break;
        end
        chk("midframe_wait_in_budget", (i < 2000), 1);
        m_text = t2;
        push_frame(t2, 9);
        wait_frames(4, 3000);

        // Reset during an EN pulse
        push_frame(t2, 0);
        pulse_refresh();
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_en) break;
        end
        chk("en_seen_in_budget", (i < 500), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_en", m_en, 1'b0);
        chk("async_rst_busy", m_busy, 1'b1);
        chk("async_rst_data", m_data, 8'h00);
        q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        push_init();
        push_frame(t2, 8);
        check_power_quiet();
        wait_frames(5, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
